// File: rtl/dc_beacon_tx_m.sv
// rtl/dc_beacon_tx_m.sv - beacon/delay-packet symbol generator ahead of the 8b10b serializer
`timescale 1ns/1ps
module dc_beacon_tx_m #(
  parameter int         DELAY_WIDTH   = 32,
  parameter int         BEACON_PERIOD = 1024,
  parameter logic [8:0] BEACON_CODE   = 9'h17E,
  parameter logic [8:0] IDLE_CODE     = 9'h1BC,
  parameter logic [8:0] PKT_START     = 9'h15C,
  parameter logic [8:0] PKT_END       = 9'h13C
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic                   delay_upd,
  input  logic [DELAY_WIDTH-1:0] delay,
  input  logic [7:0]             evt_in,
  input  logic                   evt_in_valid,
  output logic                   evt_in_ready,
  output logic [8:0]             tx_data,
  output logic [15:0]            beacon_cnt
);

  localparam logic [15:0] PCNT_LOAD = 16'(BEACON_PERIOD - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_CSUM, S_END} state_t;

  state_t                 state_q, state_d;
  logic [15:0]            pcnt_q;
  logic [1:0]             idx_q, idx_d;
  logic [DELAY_WIDTH-1:0] pend_q;
  logic [DELAY_WIDTH-1:0] pkt_q;
  logic                   pend_valid_q;
  logic [8:0]             sym_d;
  logic                   beacon_due;
  logic                   beacon_fire;
  logic                   evt_take;
  logic [7:0]             pkt_byte;
  logic [7:0]             pkt_csum;

  // The beacon slot is decided purely by the period counter, so spacing never depends on traffic.
  assign beacon_due   = ena && (pcnt_q == 16'd0);
  assign evt_in_ready = rst_n && (state_q == S_IDLE) && !beacon_due;
  assign evt_take     = evt_in_valid && evt_in_ready;

  // Packet bytes and checksum come only from the snapshot so a late delay_upd cannot tear a frame.
  assign pkt_byte = pkt_q[{idx_q, 3'b000} +: 8];
  assign pkt_csum = pkt_q[31:24] ^ pkt_q[23:16] ^ pkt_q[15:8] ^ pkt_q[7:0];

  // Period counter: free-runs while enabled, parked at the reload value while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q <= PCNT_LOAD;
    end else if (!ena) begin
      pcnt_q <= PCNT_LOAD;
    end else if (pcnt_q == 16'd0) begin
      pcnt_q <= PCNT_LOAD;
    end else begin
      pcnt_q <= pcnt_q - 16'd1;
    end
  end

  // Pending delay register and beacon-time snapshot; the snapshot always sees the old pending value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      pkt_q        <= '0;
    end else begin
      if (beacon_fire) begin
        pkt_q <= pend_q;
      end
      if (delay_upd) begin
        pend_q       <= delay;
        pend_valid_q <= 1'b1;
      end
    end
  end

  // Next-state and next-symbol selection for the beacon/packet framer.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    sym_d       = IDLE_CODE;
    beacon_fire = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (beacon_due) begin
          sym_d       = BEACON_CODE;
          beacon_fire = 1'b1;
          if (pend_valid_q) begin
            state_d = S_START;
          end
        end else if (evt_take) begin
          sym_d = {1'b0, evt_in};
        end
      end
      S_START: begin
        sym_d   = PKT_START;
        idx_d   = 2'd3;
        state_d = S_DATA;
      end
      S_DATA: begin
        sym_d = {1'b0, pkt_byte};
        idx_d = idx_q - 2'd1;
        if (idx_q == 2'd0) begin
          state_d = S_CSUM;
        end
      end
      S_CSUM: begin
        sym_d   = {1'b0, pkt_csum};
        state_d = S_END;
      end
      S_END: begin
        sym_d   = PKT_END;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, registered output symbol and beacon counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= 2'd0;
      tx_data    <= IDLE_CODE;
      beacon_cnt <= 16'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tx_data <= sym_d;
      if (beacon_fire) begin
        beacon_cnt <= beacon_cnt + 16'd1;
      end
    end
  end

endmodule
